wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
- Shares the register bank's single write port (rf_en/rf_rd/rf_data) between N writeback requesters, e.g. ALU, load unit and multicycle unit.
- Uses fair round-robin arbitration with a per-requester valid/ready handshake.
- Registers the selected write, so the bank sees it one cycle after acceptance.
- Filters writes the bank must never perform: r0 and out-of-range indices.

Parameters:
- N, 3: number of writeback requesters, 2..8.
- NREGS, 16: number of implemented registers; valid rd range is 0..NREGS-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req_valid  input  N  request i has a write pending.
- req_rd  input  5*N  destination index of request i, bits [5i+4:5i].
- req_data  input  32*N  write data of request i, bits [32i+31:32i].
- req_ready  output  N  request i accepted this cycle (one-hot or zero).
- hold  input  1  freeze the write port; no acceptance while high.
- rf_en  output  1  write enable to the register bank.
- rf_rd  output  5  destination index to the register bank.
- rf_data  output  32  write data to the register bank.
- last_grant  output  N  one-hot id of the last accepted requester.

Behaviour:
- Reset (asynchronous, immediate on rst high): rf_en=0, rf_rd=0, rf_data=0, last_grant=0, round-robin pointer ptr=0.
- Any registered write in flight at reset is dropped; rf_en falls without waiting for a clock edge.
- Grant is combinational from the current req_valid, ptr and hold.
  - hold=0: scan i = ptr, ptr+1, ..., wrapping mod N; the first i with req_valid[i]=1 gets req_ready[i]=1. All other ready bits are 0.
  - hold=1, or no valid request: req_ready is all 0.
- Transfer on requester i = req_valid[i] & req_ready[i] at a rising clk edge.
- Requester contract: keep valid, rd and data stable until transferred. The bench flags any violation.
- Transfer on i at edge k, registered at edge k (visible from edge k until edge k+1):
  - rf_rd <= rd_i; rf_data <= data_i.
  - rf_en <= 1 if 0 < rd_i < NREGS, else 0.
  - last_grant <= one-hot(i).
  - ptr <= (i+1) mod N.
- Filtered writes (rd_i = 0 or rd_i >= NREGS) are still accepted (ready=1) and still advance ptr; they are discarded with rf_en=0. r0 stays hardwired zero.
- No transfer at an edge: rf_en <= 0. rf_rd, rf_data, last_grant and ptr hold.
- Latency: exactly 1 cycle from acceptance to rf_en. Throughput: 1 write per cycle.
- Fairness: a continuously valid requester is granted within N transfers.
- Simultaneous requests: only one is granted per cycle; the rest keep waiting, with no loss and no reordering within a requester.
- hold asserted mid-stream: a transfer already accepted on the previous edge still drives rf_en for one cycle. No new acceptance occurs while hold=1.
- The bank samples rf_* at the next edge. Downstream read-after-write forwarding is outside this block.

Optional Feature:
- Macro: WB_ARB_ERR_EN.
- Defined: adds outputs err (1 bit) and err_rd (5 bits), both reset to 0.
  - First accepted transfer with rd_i >= NREGS sets err=1 (sticky until rst) and captures err_rd=rd_i. Later bad writes do not overwrite err_rd.
  - rd=0 is never an error.
- Not defined: the ports are absent. Out-of-range writes are silently discarded; behaviour is otherwise identical.

Test Plan:
- Reset then single request: req0 valid, rd=5, data=32'hDEADBEEF.
  - Expect req_ready=3'b001 the same cycle.
  - Next cycle: rf_en=1, rf_rd=5, rf_data=DEADBEEF, last_grant=001.
  - The cycle after: rf_en=0.
- All three valid continuously, rd=1/2/3 from ptr=0: grants in order 0,1,2,0,... one per cycle; rf_rd sequence 1,2,3,1; no idle cycles.
- Filtering: req1 rd=0 and then rd=20. Each is accepted (ready=1) and ptr advances, but rf_en stays 0 both cycles.
  - With WB_ARB_ERR_EN: err=1, err_rd=20 after the second transfer.
- hold: assert hold while req2 valid rd=7 → req_ready=0 for 4 cycles, rf_en=0. Deassert → accepted the same cycle, then rf_en=1 with rf_rd=7.
- Asynchronous reset mid-stream: assert rst between edges while rf_en=1 → rf_en, rf_rd, rf_data drop to 0 immediately. After release with req1 and req2 valid, req1 is granted first (ptr=0 → scan finds 1).
- Fairness: req0 always valid, req2 valid from cycle 3 → req2 is granted within 3 transfers of asserting valid, and its data is written unchanged.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing one register-bank write port among N writeback requesters.
// Optional WB_ARB_ERR_EN adds sticky err/err_rd reporting of out-of-range destinations.
module wb_port_arbiter #(
  parameter int unsigned N     = 3,
  parameter int unsigned NREGS = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  input  logic [5*N-1:0]  req_rd,
  input  logic [32*N-1:0] req_data,
  output logic [N-1:0]    req_ready,
  input  logic            hold,
  output logic            rf_en,
  output logic [4:0]      rf_rd,
  output logic [31:0]     rf_data,
  output logic [N-1:0]    last_grant
`ifdef WB_ARB_ERR_EN
  ,
  output logic            err,
  output logic [4:0]      err_rd
`endif
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic          r_en;
  logic [4:0]    r_rd;
  logic [31:0]   r_data;
  logic [N-1:0]  r_last;

  logic [N-1:0]  w_ready;
  logic [PW-1:0] w_gidx;
  logic [PW-1:0] w_j;
  logic          w_found;
  logic [4:0]    w_rd;
  logic [31:0]   w_data;
  logic          w_in_range;
  logic [PW-1:0] w_ptr_nxt;

  // Scan from r_ptr upward (wrapping) and grant the first valid requester.
  always_comb begin
    w_ready = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    w_j     = '0;
    if (!hold) begin
      for (int unsigned k = 0; k < N; k++) begin
        w_j = PW'((32'(r_ptr) + k) % N);
        if (!w_found && req_valid[w_j]) begin
          w_found      = 1'b1;
          w_gidx       = w_j;
          w_ready[w_j] = 1'b1;
        end
      end
    end
  end

  assign w_rd       = req_rd[5*32'(w_gidx) +: 5];
  assign w_data     = req_data[32*32'(w_gidx) +: 32];
  assign w_in_range = (w_rd != 5'd0) && (32'(w_rd) < NREGS);
  assign w_ptr_nxt  = (32'(w_gidx) == N - 1) ? '0 : PW'(w_gidx + 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr  <= '0;
      r_en   <= 1'b0;
      r_rd   <= '0;
      r_data <= '0;
      r_last <= '0;
    end else if (w_found) begin
      r_ptr  <= w_ptr_nxt;
      r_en   <= w_in_range;
      r_rd   <= w_rd;
      r_data <= w_data;
      r_last <= w_ready;
    end else begin
      r_en   <= 1'b0;
    end
  end

`ifdef WB_ARB_ERR_EN
  logic       r_err;
  logic [4:0] r_err_rd;

  // Only the first out-of-range destination is captured; rd=0 is not an error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err    <= 1'b0;
      r_err_rd <= '0;
    end else if (w_found && !r_err && (32'(w_rd) >= NREGS)) begin
      r_err    <= 1'b1;
      r_err_rd <= w_rd;
    end
  end

  assign err    = r_err;
  assign err_rd = r_err_rd;
`endif

  assign req_ready  = w_ready;
  assign rf_en      = r_en;
  assign rf_rd      = r_rd;
  assign rf_data    = r_data;
  assign last_grant = r_last;

endmodule
